// File: rtl/ddr3_req_arbiter_pkg.sv
// Shared types for the DDR3 request arbiter.
// DDR3_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package ddr3_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    DRAIN = 2'd2
  } ddr3_arb_state_t;

  localparam int DDR3_ARB_MAX_CH = 8;

endpackage

// File: rtl/ddr3_arb_pick.sv
// One-hot winner select: first requester at or after the start pointer.
// Fixed-priority builds tie the pointer to zero.
module ddr3_arb_pick #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_gnt
);

  logic           w_found;
  logic [PTR_W:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (w_idx >= (PTR_W+1)'(NUM_CH))
        w_idx = w_idx - (PTR_W+1)'(NUM_CH);
      if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
        o_gnt[w_idx[PTR_W-1:0]] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_req_arbiter.sv
// N-channel DDR3 port arbiter with grant locking and busy tracking.
// Define DDR3_ARB_ROUND_ROBIN_EN for round-robin winner selection.
module ddr3_req_arbiter
  import ddr3_req_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_request,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0]        ch_rd,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH-1:0]        ch_grant,
  input  logic [DATA_W-1:0]        ddr3_dout,
  input  logic                     ddr3_ready,
  output logic [ADDR_W-1:0]        ddr3_addr,
  output logic                     ddr3_rd,
  output logic                     ddr3_wr,
  output logic [DATA_W-1:0]        ddr3_din,
  output logic                     ddr3_request,
  output logic                     proto_err
);

  localparam int PTR_W = $clog2(NUM_CH);

  ddr3_arb_state_t   r_state;
  logic [NUM_CH-1:0] r_grant;
  logic              r_busy;
  logic              r_err;

  logic [NUM_CH-1:0] w_pick;
  logic [PTR_W-1:0]  w_ptr;
  logic              w_own_req;
  logic              w_own_rd;
  logic              w_own_wr;
  logic              w_strobe;
  logic              w_issue;
  logic              w_err_set;
  logic              w_done;
  logic              w_release;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;
  logic              w_unused_dout;

  // Read data is broadcast to the channels outside this block.
  assign w_unused_dout = ^ddr3_dout;

`ifdef DDR3_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_next_ptr;

  assign w_ptr = r_rr_ptr;

  always_comb begin
    w_next_ptr = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (r_grant[i])
        w_next_ptr = (i == NUM_CH-1) ? '0 : PTR_W'(i+1);
  end
`else
  assign w_ptr = '0;
`endif

  ddr3_arb_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_pick (
    .i_req (ch_request),
    .i_ptr (w_ptr),
    .o_gnt (w_pick)
  );

  always_comb begin
    w_addr = '0;
    w_din  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_grant[i]) begin
        w_addr = w_addr | ch_addr[i*ADDR_W +: ADDR_W];
        w_din  = w_din  | ch_din[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_own_req = |(ch_request & r_grant);
  assign w_own_rd  = |(ch_rd & r_grant);
  assign w_own_wr  = |(ch_wr & r_grant);
  assign w_strobe  = w_own_rd | w_own_wr;
  assign w_done    = r_busy & ddr3_ready;

  assign w_issue = reset_n & (r_state == OWNED)
                 & w_strobe & ddr3_ready & ~r_busy;

  assign w_err_set = (r_state != IDLE) & w_strobe
                   & ((w_own_rd & w_own_wr) | r_busy | ~ddr3_ready);

  // Busy already clear in DRAIN means the access finished on entry.
  assign w_release =
      ((r_state == OWNED) & ~w_own_req & ~r_busy & ~w_issue)
    | ((r_state == DRAIN) & (~r_busy | w_done));

  assign ddr3_wr      = w_issue & w_own_wr;
  assign ddr3_rd      = w_issue & w_own_rd & ~w_own_wr;
  assign ddr3_addr    = w_addr;
  assign ddr3_din     = w_din;
  assign ddr3_request = |r_grant;
  assign ch_grant     = r_grant;
  assign proto_err    = r_err;
  assign ch_ready     = r_grant & {NUM_CH{(r_state == OWNED)
                                          & ~r_busy & ddr3_ready}};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
`ifdef DDR3_ARB_ROUND_ROBIN_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      if (w_err_set)
        r_err <= 1'b1;
      if (w_issue)
        r_busy <= 1'b1;
      else if (w_done)
        r_busy <= 1'b0;
`ifdef DDR3_ARB_ROUND_ROBIN_EN
      if (w_release)
        r_rr_ptr <= w_next_ptr;
`endif
      unique case (r_state)
        IDLE: begin
          if (|ch_request) begin
            r_grant <= w_pick;
            r_state <= OWNED;
          end
        end
        OWNED: begin
          if (w_release) begin
            r_grant <= '0;
            r_state <= IDLE;
          end else if (!w_own_req) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_release) begin
            r_grant <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Bench for ddr3_req_arbiter: directed table, corner sequences, random vs model.
// Round-robin checks run when DDR3_ARB_ROUND_ROBIN_EN is defined.
module tb_ddr3_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 8;

`ifdef DDR3_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  ch_request, ch_rd, ch_wr;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_din;
  logic [N-1:0]  ch_ready, ch_grant;
  logic [DW-1:0] ddr3_dout;
  logic          ddr3_ready;
  logic [AW-1:0] ddr3_addr;
  logic          ddr3_rd, ddr3_wr;
  logic [DW-1:0] ddr3_din;
  logic          ddr3_request, proto_err;

  always #5 clk = ~clk;

  ddr3_req_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ch_request   (ch_request),
    .ch_addr      (ch_addr),
    .ch_rd        (ch_rd),
    .ch_wr        (ch_wr),
    .ch_din       (ch_din),
    .ch_ready     (ch_ready),
    .ch_grant     (ch_grant),
    .ddr3_dout    (ddr3_dout),
    .ddr3_ready   (ddr3_ready),
    .ddr3_addr    (ddr3_addr),
    .ddr3_rd      (ddr3_rd),
    .ddr3_wr      (ddr3_wr),
    .ddr3_din     (ddr3_din),
    .ddr3_request (ddr3_request),
    .proto_err    (proto_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: owner index (-1 = none), drain flag, busy, sticky error.
  int m_owner = -1;
  bit m_drain, m_busy, m_err, m_on;
  int m_ptr;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_winner();
    int start = RR ? m_ptr : 0;
    for (int i = 0; i < N; i++)
      if (ch_request[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  task automatic model_check();
    logic [N-1:0]  eg, er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit ord, owr, iss;
    eg = '0; er = '0; ea = '0; ed = '0; ord = 0; owr = 0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ord = ch_rd[m_owner];
      owr = ch_wr[m_owner];
      ea  = ch_addr[m_owner*AW +: AW];
      ed  = ch_din[m_owner*DW +: DW];
      if (!m_drain && !m_busy && ddr3_ready) er[m_owner] = 1'b1;
    end
    iss = reset_n && m_owner >= 0 && !m_drain && (ord || owr)
          && ddr3_ready && !m_busy;
    chk("grant", ch_grant, eg);
    chk("ch_ready", ch_ready, er);
    chk("ddr3_rd", ddr3_rd, iss && ord && !owr);
    chk("ddr3_wr", ddr3_wr, iss && owr);
    chk("ddr3_addr", ddr3_addr, ea);
    chk("ddr3_din", ddr3_din, ed);
    chk("ddr3_request", ddr3_request, m_owner >= 0);
    chk("proto_err", proto_err, m_err);
  endtask

  task automatic model_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_drain = 0;
  endtask

  task automatic model_update();
    bit ord, owr, iss, nb;
    if (!reset_n) begin
      m_owner = -1; m_drain = 0; m_busy = 0; m_err = 0; m_ptr = 0;
      m_on = 1;
      return;
    end
    ord = (m_owner >= 0) ? ch_rd[m_owner] : 1'b0;
    owr = (m_owner >= 0) ? ch_wr[m_owner] : 1'b0;
    iss = m_owner >= 0 && !m_drain && (ord || owr) && ddr3_ready && !m_busy;
    if (m_owner >= 0 && (ord || owr) && ((ord && owr) || m_busy || !ddr3_ready))
      m_err = 1;
    nb = iss ? 1'b1 : (m_busy && ddr3_ready) ? 1'b0 : m_busy;
    if (m_owner < 0) begin
      m_owner = pick_winner();
    end else if (!m_drain) begin
      if (!ch_request[m_owner]) begin
        if (m_busy || iss) m_drain = 1;
        else model_release();
      end
    end else if (!m_busy || ddr3_ready) begin
      model_release();
    end
    m_busy = nb;
  endtask

  task automatic pre();
    #3;
    if (m_on) model_check();
  endtask

  task automatic post();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic idle_inputs();
    ch_request = '0; ch_rd = '0; ch_wr = '0;
    ddr3_ready = 1'b1; ddr3_dout = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic [N-1:0] req, rd, wr;
    logic         rdy;
    logic [N-1:0] eg, er;
    logic         erd, ewr, eerr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int low_cnt, rd_cnt, pulse_cnt, g_idx, wait_n;

    tbl[0]  = '{4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 0, 0};
    tbl[1]  = '{4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0010, 0, 0, 0};
    tbl[2]  = '{4'b1011, 4'b0001, 4'b0000, 1'b1, 4'b0010, 4'b0010, 0, 0, 0};
    tbl[3]  = '{4'b1011, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1, 0, 0};
    tbl[4]  = '{4'b1011, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 0, 0, 0};
    tbl[5]  = '{4'b1011, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0000, 0, 0, 0};
    tbl[6]  = '{4'b1011, 4'b0000, 4'b1000, 1'b1, 4'b0010, 4'b0010, 0, 0, 0};
    tbl[7]  = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0010, 0, 0, 0};
    tbl[8]  = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 0, 0};
    tbl[9]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 0, 1, 0};
    tbl[10] = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0000, 0, 0, 1};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0001, 0, 0, 1};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 0, 1};

    m_on = 0;
    for (int i = 0; i < N; i++) begin
      ch_addr[i*AW +: AW] = AW'($urandom) | AW'(1);
      ch_din[i*DW +: DW]  = DW'($urandom) | DW'(1);
    end

    // Reset held while every channel requests.
    reset_n = 1'b0;
    idle_inputs();
    ch_request = 4'b1111;
    #1;
    step();
    step();
    pre();
    chk("rst_grant", ch_grant, 0);
    chk("rst_request", ddr3_request, 0);
    chk("rst_addr", ddr3_addr, 0);
    chk("rst_err", proto_err, 0);
    post();
    reset_n = 1'b1;

    // Directed table: priority, locking, access, rd&wr error.
    for (int r = 0; r < 13; r++) begin
      ch_request = tbl[r].req;
      ch_rd      = tbl[r].rd;
      ch_wr      = tbl[r].wr;
      ddr3_ready = tbl[r].rdy;
      pre();
      chk($sformatf("tbl%0d_grant", r), ch_grant, tbl[r].eg);
      chk($sformatf("tbl%0d_ready", r), ch_ready, tbl[r].er);
      chk($sformatf("tbl%0d_rd", r), ddr3_rd, tbl[r].erd);
      chk($sformatf("tbl%0d_wr", r), ddr3_wr, tbl[r].ewr);
      chk($sformatf("tbl%0d_err", r), proto_err, tbl[r].eerr);
      post();
    end

    // Read on ch2 with three wait cycles.
    do_reset();
    ch_addr[2*AW +: AW] = 28'h0123456;
    ch_request = 4'b0100;
    step();
    step();
    ch_rd = 4'b0100;
    pre();
    chk("acc_rd_issue", ddr3_rd, 1);
    chk("acc_addr", ddr3_addr, 28'h0123456);
    rd_cnt = int'(ddr3_rd);
    low_cnt = 0;
    post();
    ch_rd = '0;
    for (int c = 0; c < 4; c++) begin
      ddr3_ready = (c == 3);
      ddr3_dout  = (c == 3) ? 8'hA5 : 8'h00;
      pre();
      if (!ch_ready[2]) low_cnt++;
      rd_cnt += int'(ddr3_rd);
      post();
    end
    pre();
    chk("acc_ready_back", ch_ready[2], 1);
    chk("acc_low_cycles", low_cnt, 4);
    chk("acc_rd_pulses", rd_cnt, 1);
    post();

    // Owner ch3 drops request while a write is outstanding.
    do_reset();
    ch_request = 4'b1000;
    step();
    step();
    ch_wr = 4'b1000;
    pre();
    chk("drain_wr_issue", ddr3_wr, 1);
    post();
    ch_wr = '0;
    ch_request = '0;
    ddr3_ready = 1'b0;
    pulse_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      pre();
      chk("drain_grant_held", ch_grant, 4'b1000);
      if (ch_ready[3]) pulse_cnt++;
      post();
    end
    ddr3_ready = 1'b1;
    pre();
    if (ch_ready[3]) pulse_cnt++;
    post();
    pre();
    chk("drain_idle", ch_grant, 0);
    chk("drain_no_ready", pulse_cnt, 0);
    post();

    if (RR) begin
      do_reset();
      ch_request = 4'b1111;
      for (int n = 0; n < 5; n++) begin
        wait_n = 0;
        g_idx = -1;
        while (g_idx < 0 && wait_n < 10) begin
          pre();
          for (int i = 0; i < N; i++) if (ch_grant[i]) g_idx = i;
          post();
          wait_n++;
        end
        chk($sformatf("rr_order%0d", n), g_idx, n % N);
        if (g_idx < 0) break;
        ch_rd[g_idx] = 1'b1;
        step();
        ch_rd = '0;
        ch_request[g_idx] = 1'b0;
        step();
        step();
        ch_request[g_idx] = 1'b1;
      end
    end

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(299) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(11) == 0) ch_request[i] = ~ch_request[i];
        ch_rd[i] = ($urandom_range(5) == 0);
        ch_wr[i] = ($urandom_range(5) == 0);
        if ($urandom_range(3) == 0) begin
          ch_addr[i*AW +: AW] = AW'($urandom);
          ch_din[i*DW +: DW]  = DW'($urandom);
        end
      end
      ddr3_ready = ($urandom_range(3) != 0);
      ddr3_dout  = DW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
